// File: rtl/mult_sequencer_pkg.sv
// Shared widths, FSM encoding and result codes for the multiply sequencer.
package mult_sequencer_pkg;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int FIFO_W = 2 * OP_W;

  localparam logic [PROD_W-1:0] ERR_CODE = 16'hFFFF;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } opnd_t;

  // A zero operand means the product is known without running the multiplier.
  function automatic logic has_zero(opnd_t o);
    return (o.a == '0) || (o.b == '0);
  endfunction
endpackage

// File: rtl/mult_operand_fifo.sv
// Operand-pair FIFO; full is not relieved by a pop in the same cycle.
module mult_operand_fifo
  import mult_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FIFO_W-1:0] wdata,
  input  logic              pop,
  output logic [FIFO_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [FIFO_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       cnt;
  logic              do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign rdata   = mem[rptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/mult_sequencer.sv
// Feeds queued operand pairs to an external shift-add multiplier and holds each result until taken.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic [OP_W-1:0]   ma,
  output logic [OP_W-1:0]   mb,
  output logic              ms,
  input  logic              mdone,
  input  logic [PROD_W-1:0] mrp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_p,
  output logic              out_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  opnd_t         head;
  logic          full, empty, pop;

  assign pop      = (state == S_IDLE) && !empty;
  assign in_ready = !full;

  mult_operand_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata ({in_a, in_b}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ma        <= '0;
      mb        <= '0;
      ms        <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (!empty) begin
          if (has_zero(head)) begin
            out_p     <= '0;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else begin
            ma    <= head.a;
            mb    <= head.b;
            ms    <= 1'b1;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ms    <= 1'b0;
          cnt   <= '0;
          state <= S_WAIT;
        end
        // Completion wins over a timeout landing in the same cycle.
        S_WAIT: begin
          if (mdone) begin
            out_p     <= mrp;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else if (cnt == TO_LAST) begin
            out_p     <= ERR_CODE;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer with a behavioural downstream multiplier.
module tb_mult_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  in_a = '0, in_b = '0, ma, mb;
  logic        ms, mdone = 1'b0, out_valid, out_ready = 1'b1, out_err;
  logic [15:0] mrp = '0, out_p;

  int n_chk = 0, n_pass = 0;
  int ms_cnt = 0;
  int mult_delay = 3;
  bit mult_en = 1'b1;
  int rst_epoch = 0;
  logic [16:0] q[$];

  mult_sequencer #(.DEPTH(4), .TIMEOUT(512)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .ma(ma), .mb(mb), .ms(ms), .mdone(mdone),
    .mrp(mrp), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: compare each handshaken result against the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_result", {15'b0, out_err, out_p}, 32'hDEAD);
      else chk("result", {15'b0, out_err, out_p}, {15'b0, q.pop_front()});
    end
  end

  always @(negedge clk) if (ms) ms_cnt++;

  // Downstream multiplier model: product after mult_delay cycles.
  always begin
    logic [7:0] a, b;
    int d, ep;
    @(negedge clk);
    if (ms && mult_en) begin
      a = ma; b = mb; d = mult_delay; ep = rst_epoch;
      repeat (d) @(posedge clk);
      #1;
      if (ep == rst_epoch) chk("operand_hold", {16'b0, ma, mb}, {16'b0, a, b});
      mdone = 1'b1;
      mrp = 16'(a) * 16'(b);
      @(posedge clk); #1;
      mdone = 1'b0;
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [16:0] exp);
    bit ok = 1'b0;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        q.push_back(exp);
      end
    end
    #1;
    if (!ok) chk("push_accept", 0, 1);
  endtask

  task automatic wait_valid(input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    if (!ok) chk("wait_valid", 0, 1);
  endtask

  task automatic wait_drain(input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      chk("drain", q.size(), 0);
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int m0;
    bit bad;
    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ms", ms, 0);
    chk("rst_ma_mb", {ma, mb}, 0);
    chk("rst_out", {out_err, out_p}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // (12,10), MDONE 3 cycles after MS, result held until out_ready
    out_ready = 1'b0; mult_delay = 3; m0 = ms_cnt;
    push(8'd12, 8'd10, {1'b0, 16'd120});
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("issue_latency_ms", ms, 1);
    wait_valid(50);
    repeat (3) @(negedge clk);
    chk("hold_until_ready", out_valid, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain(20);
    chk("ms_count_t1", ms_cnt - m0, 1);

    // Zero operands bypass the multiplier
    m0 = ms_cnt;
    push(8'd0, 8'd77, {1'b0, 16'd0});
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bypass_latency", out_valid, 1);
    push(8'd5, 8'd0, {1'b0, 16'd0});
    in_valid = 1'b0;
    wait_drain(20);
    chk("ms_count_bypass", ms_cnt - m0, 0);

    // Back-pressure: 1 in flight + 4 queued fills the FIFO
    m0 = ms_cnt; mult_delay = 30;
    push(8'd1, 8'd2,  {1'b0, 16'd2});
    push(8'd3, 8'd4,  {1'b0, 16'd12});
    push(8'd5, 8'd6,  {1'b0, 16'd30});
    push(8'd7, 8'd8,  {1'b0, 16'd56});
    push(8'd9, 8'd10, {1'b0, 16'd90});
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    push(8'd11, 8'd12, {1'b0, 16'd132});
    in_valid = 1'b0;
    wait_drain(400);
    chk("ms_count_fill", ms_cnt - m0, 6);

    // Timeout with the multiplier never answering
    mult_en = 1'b0; m0 = ms_cnt;
    push(8'd255, 8'd255, {1'b1, 16'hFFFF});
    in_valid = 1'b0;
    wait_drain(700);
    chk("ms_count_timeout", ms_cnt - m0, 1);
    mult_en = 1'b1; mult_delay = 1;

    // Long hold: result stable, no new issue, FIFO still accepting
    out_ready = 1'b0;
    push(8'd3, 8'd3, {1'b0, 16'd9});
    in_valid = 1'b0;
    wait_valid(50);
    @(posedge clk); #1;
    push(8'd2, 8'd2, {1'b0, 16'd4});
    in_valid = 1'b0;
    m0 = ms_cnt; bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || out_p != 16'd9 || out_err || ms) bad = 1'b1;
    end
    chk("hold_stable", bad, 0);
    chk("hold_no_ms", ms_cnt - m0, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain(50);

    // Reset during WAIT with two pairs queued
    mult_delay = 40;
    push(8'd4, 8'd4, {1'b0, 16'd16});
    push(8'd6, 8'd6, {1'b0, 16'd36});
    push(8'd7, 8'd7, {1'b0, 16'd49});
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1; rst_epoch++;
    q.delete();
    #1;
    chk("midrst_ma_mb", {ma, mb}, 0);
    chk("midrst_out", {out_valid, ms, out_err, out_p}, 0);
    chk("midrst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bad = 1'b0; m0 = ms_cnt;
    repeat (60) begin
      @(negedge clk);
      if (out_valid || ms) bad = 1'b1;
    end
    chk("late_mdone_ignored", bad, 0);
    chk("no_ms_after_rst", ms_cnt - m0, 0);

    chk("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, sets operand FIFO entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 512, sets the maximum cycles allowed in WAIT before the job is aborted.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset; asynchronous, active-high.
REQ-005 IN_VALID  input  1  operand pair offered; IN_READY  output  1  FIFO can accept.
REQ-006 IN_A  input  8  multiplicand; IN_B  input  8  multiplier.
REQ-007 MA  output  8  and MB  output  8  operands driven to the downstream shift-add multiplier, held stable from ISSUE until the job leaves WAIT.
REQ-008 MS  output  1  multiplier start, one-cycle pulse.
REQ-009 MDONE  input  1  multiplier completion; MRP  input  16  multiplier product, valid while MDONE=1.
REQ-010 OUT_VALID  output  1, OUT_READY  input  1, OUT_P  output  16  result, OUT_ERR  output  1  timeout flag for the held result.

Function
REQ-011 Transfer on IN_VALID&IN_READY at a rising edge writes {IN_A,IN_B} into the FIFO tail.
REQ-012 IN_READY = FIFO not full; a pop in the same cycle does not raise IN_READY (no full-bypass).
REQ-013 FIFO pointers wrap modulo DEPTH; occupancy counter is 0..DEPTH inclusive.
REQ-014 FSM states: IDLE, ISSUE, WAIT, HOLD.
REQ-015 IDLE, FIFO non-empty, head A!=0 and B!=0: pop, register MA/MB, go ISSUE.
REQ-016 IDLE, FIFO non-empty, head A==0 or B==0: pop, OUT_P<=0, OUT_ERR<=0, go HOLD (multiplier bypassed, MS never pulsed).
REQ-017 ISSUE: MS=1 for exactly this one cycle; next state WAIT, timeout counter cleared.
REQ-018 WAIT: on MDONE=1, OUT_P<=MRP, OUT_ERR<=0, go HOLD; MDONE in any other state is ignored.
REQ-019 WAIT: counter increments each cycle without MDONE; reaching TIMEOUT sets OUT_P<=16'hFFFF, OUT_ERR<=1, go HOLD.
REQ-020 HOLD: OUT_VALID=1; OUT_P/OUT_ERR stable; on OUT_READY=1 go IDLE.
REQ-021 OUT_VALID=1 only in HOLD; it is never lowered without OUT_READY.
REQ-022 Minimum latency, non-zero operands into an empty, idle block: accept edge t, pop t+1, MS high in cycle t+1..t+2, OUT_VALID no earlier than one cycle after MDONE.
REQ-023 Zero-bypass latency: OUT_VALID asserted in the cycle after the pop edge.
REQ-024 FIFO accepts new input in every state, including HOLD and WAIT.

Reset
REQ-025 RST=1 forces immediately: state IDLE, FIFO empty, MA=MB=0, MS=0, OUT_VALID=0, OUT_P=0, OUT_ERR=0, counter 0, IN_READY=1 on the first edge after release.
REQ-026 Reset mid-job discards queued operands and any in-flight job; a later MDONE is ignored until a new ISSUE.

Structure
REQ-027 State encoding, operand/product widths (8, 16), and the 16'hFFFF error code reside in a shared package.
REQ-028 The FIFO is one sub-module, mult_operand_fifo (DEPTH-parameterised, 16-bit data); the FSM and output register stay in the top.

Verification
REQ-029 Push (12,10), MDONE 3 cycles after MS with MRP=120 -> one MS pulse, OUT_P=120, OUT_ERR=0, OUT_VALID until OUT_READY.
REQ-030 Push (0,77) then (5,0) -> no MS pulse, two results OUT_P=0 in order.
REQ-031 Push 5 pairs, DEPTH=4, multiplier stalled -> IN_READY=0 after 4 held in FIFO plus 1 in flight; resumes after pop; order preserved.
REQ-032 Push (255,255), MDONE never asserted -> after 512 WAIT cycles OUT_P=16'hFFFF, OUT_ERR=1.
REQ-033 OUT_READY held 0 for 20 cycles in HOLD -> OUT_P stable, no new MS, FIFO still accepts.
REQ-034 RST asserted in WAIT with 2 queued -> outputs reset asynchronously, FIFO empty, late MDONE produces no OUT_VALID.
